// File: rtl/multi_ch_step_stim_if.sv
// rtl/multi_ch_step_stim_if.sv - control and channel bus of the step/square stimulus engine
interface multi_ch_step_stim_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 18
);
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] amp;
  logic [N_CH*WIDTH-1:0]   v_out;
  logic [N_CH*WIDTH-1:0]   v_in;
  logic                    busy;
  logic [N_CH-1:0]         settled;
  logic                    done;
  logic                    timeout;

  modport master (
    output start, mode, amp, v_out,
    input  v_in, busy, settled, done, timeout
  );

  modport slave (
    input  start, mode, amp, v_out,
    output v_in, busy, settled, done, timeout
  );
endinterface

// File: rtl/multi_ch_step_stim.sv
// rtl/multi_ch_step_stim.sv - multi-channel step/square stimulus with per-channel settle detect
// Square mode is compiled only when MULTI_CH_STIM_SQUARE_EN is defined; otherwise every run is step mode.
module multi_ch_step_stim #(
  parameter int N_CH          = 4,
  parameter int WIDTH         = 18,
  parameter int TOL           = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_CYCLES    = 4096,
  parameter int HALF_PERIOD   = 256,
  parameter int N_PERIODS     = 4
) (
  input logic                clk,
  input logic                rst,
  multi_ch_step_stim_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int              SCW      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0]  SC_MAX   = SCW'(SETTLE_CYCLES);
  localparam logic [31:0]     MAX_LAST = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]     SQ_LAST  = 32'(2 * HALF_PERIOD * N_PERIODS - 1);

  logic [1:0]              state;
  logic signed [WIDTH-1:0] amp_q;
  logic [31:0]             cyc;
  logic [SCW-1:0]          cnt [N_CH];
  logic [N_CH-1:0]         in_tol;
  logic [N_CH*WIDTH-1:0]   v_in_q;
  logic                    busy_q;
  logic [N_CH-1:0]         settled_q;
  logic                    done_q;
  logic                    timeout_q;

  assign bus.v_in    = v_in_q;
  assign bus.busy    = busy_q;
  assign bus.settled = settled_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;

  // One extra bit on the error keeps v_out - amp exact over the full signed range.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic signed [WIDTH-1:0] vo;
    logic signed [WIDTH:0]   err;
    logic [WIDTH:0]          mag;
    assign vo         = bus.v_out[g*WIDTH +: WIDTH];
    assign err        = {vo[WIDTH-1], vo} - {amp_q[WIDTH-1], amp_q};
    assign mag        = err[WIDTH] ? -err : err;
    assign in_tol[g]  = 32'(mag) <= 32'(TOL);
  end

`ifdef MULTI_CH_STIM_SQUARE_EN
  localparam int              PW      = $clog2(HALF_PERIOD + 1);
  localparam logic [PW-1:0]   HP_LAST = PW'(HALF_PERIOD - 1);
  localparam logic signed [WIDTH-1:0] AMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] AMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic                    sq_q;
  logic [PW-1:0]           ph;
  logic                    neg;
  logic signed [WIDTH-1:0] amp_neg;

  assign amp_neg = (amp_q == AMP_MIN) ? AMP_MAX : -amp_q;
`else
  logic unused_sq;
  assign unused_sq = bus.mode ^ SQ_LAST[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      amp_q     <= '0;
      cyc       <= '0;
      v_in_q    <= '0;
      busy_q    <= 1'b0;
      settled_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
`ifdef MULTI_CH_STIM_SQUARE_EN
      sq_q      <= 1'b0;
      ph        <= '0;
      neg       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_DRIVE;
            amp_q     <= bus.amp;
            cyc       <= '0;
            v_in_q    <= {N_CH{bus.amp}};
            busy_q    <= 1'b1;
            settled_q <= '0;
            timeout_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
`ifdef MULTI_CH_STIM_SQUARE_EN
            sq_q      <= bus.mode;
            ph        <= '0;
            neg       <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          cyc <= cyc + 1'b1;
`ifdef MULTI_CH_STIM_SQUARE_EN
          if (sq_q) begin
            if (ph == HP_LAST) begin
              ph     <= '0;
              neg    <= ~neg;
              v_in_q <= {N_CH{neg ? amp_q : amp_neg}};
            end else begin
              ph <= ph + 1'b1;
            end
            if (cyc == SQ_LAST) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              v_in_q <= '0;
            end
          end else
`endif
          begin
            for (int k = 0; k < N_CH; k++) begin
              if (in_tol[k]) begin
                if (cnt[k] != SC_MAX) cnt[k] <= cnt[k] + 1'b1;
                if (cnt[k] == SC_MAX - 1'b1) settled_q[k] <= 1'b1;
              end else begin
                cnt[k] <= '0;
              end
            end
            // Registered settled flags decide the exit, so all-settled beats a coincident timeout.
            if (&settled_q) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              v_in_q <= '0;
            end else if (cyc == MAX_LAST) begin
              state     <= S_DONE;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              v_in_q    <= '0;
              timeout_q <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/multi_ch_step_stim.md
# multi_ch_step_stim

Parametrised stimulus-and-settle engine for filter emulation benches. It drives `N_CH` fixed-point analog inputs with a step or square waveform and watches the matching `N_CH` filter outputs. It flags per-channel settling against a tolerance and reports completion or timeout. It sits between the emulation control and one or more filter instances, replacing constant-input benches.

## Interface
Parameters:
- `N_CH`, 4: number of channels, 1..16.
- `WIDTH`, 18: signed fixed-point width of every `v_in`/`v_out` word (same exponent as filter I/O).
- `TOL`, 64: settle tolerance in LSBs, unsigned.
- `SETTLE_CYCLES`, 16: consecutive in-tolerance cycles required to declare settled, ≥1.
- `MAX_CYCLES`, 4096: step-mode timeout, cycles after start.
- `HALF_PERIOD`, 256: square-mode half period in cycles, ≥1.
- `N_PERIODS`, 4: square-mode full periods before done, ≥1.

Ports:
- `clk` in 1: emulator clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle run request.
- `mode` in 1: 0 = step, 1 = square.
- `amp` in WIDTH: signed stimulus amplitude.
- `v_out` in N_CH*WIDTH: filter outputs; channel k at bits [k*WIDTH +: WIDTH].
- `v_in` out N_CH*WIDTH: stimulus to filters, same packing.
- `busy` out 1: run in progress.
- `settled` out N_CH: per-channel settled flags.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: sticky; a step run ended without all channels settled.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: `v_in`=0. On `start`=1, latch `amp` and `mode`, clear `settled`, `timeout` and counters, then go to DRIVE.
- DRIVE, step mode: every channel's `v_in`=latched amp. Per channel, `err` = v_out − amp, computed at WIDTH+1 bits signed, no overflow. If |err| ≤ TOL, increment that channel's run counter, saturating at SETTLE_CYCLES. Otherwise clear the counter.
  - `settled[k]` sets when counter k reaches SETTLE_CYCLES. It stays set for the rest of the run.
  - When all `settled` are 1, go to DONE.
  - If the cycle counter reaches MAX_CYCLES first, set `timeout` and go to DONE.
  - If both occur in the same cycle, all-settled wins and `timeout` stays 0.
- DRIVE, square mode: `v_in` is +amp for HALF_PERIOD cycles, then −amp for HALF_PERIOD cycles, repeating. Negating the most-negative amp saturates to the most-positive value.
  - After N_PERIODS full periods go to DONE.
  - No settle check; `settled` stays 0 and `timeout` stays 0.
- DONE: assert `done` for one cycle, set `v_in`=0, go to IDLE.
- `start` is ignored outside IDLE.
- `rst` in any state aborts the run. The next cycle is IDLE with all outputs at their reset values.

## Timing
- Reset values: `v_in`=0, `busy`=0, `settled`=0, `done`=0, `timeout`=0. State is IDLE and all counters are 0.
- Start latency: `start` in cycle t gives `busy`=1 and `v_in`=amp from cycle t+1.
- All outputs are registered; there are no combinational paths from input to output.
- Settle decision: `v_out` sampled in cycle t counts toward the run. `settled[k]` is visible in cycle t+1 after the SETTLE_CYCLES-th consecutive in-tolerance sample.
- The all-settled state transition and `done` occur one cycle after the last `settled` bit sets.
- `busy` falls in the same cycle `done` pulses.
- Square edges: `v_in` flips every HALF_PERIOD cycles exactly. The run occupies 2·HALF_PERIOD·N_PERIODS DRIVE cycles.
- Timeout: `done` and `timeout` assert MAX_CYCLES+1 cycles after the `start` cycle.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `MULTI_CH_STIM_SQUARE_EN` defined: square mode is available as described.
- Not defined: square logic is not compiled, `mode` is ignored and every run is step mode.

## Test plan
- N_CH=2, amp=1000, v_out tracks amp exactly from cycle 1 → both `settled` bits set at start+17, `done` at start+18, `timeout`=0.
- Step run, ch1 v_out held at amp+65 (TOL=64) → ch0 settles, ch1 never does. After MAX_CYCLES: `timeout`=1, `done` pulses, `settled`=2'b01.
- Step run, ch0 in tolerance for 15 cycles, one out-of-tolerance sample, then in tolerance → settles 16 cycles after the glitch, not earlier.
- Square mode (macro defined), HALF_PERIOD=4, N_PERIODS=2, amp=−2^(WIDTH−1) → `v_in` alternates between −2^(WIDTH−1) and 2^(WIDTH−1)−1 every 4 cycles, `done` after 16 DRIVE cycles. Same stimulus with the macro undefined → step behaviour.
- `rst` asserted mid-DRIVE → next cycle all outputs are 0. A `start` pulsed while busy is ignored; a `start` in the cycle after `done` begins a new run.
